mpu_store_stream: RTL
=====================

Name: mpu_store_stream

Overview:
- Parametrised store engine that moves one matrix from the MPU register file to an external memory or file sink.
- Walks every (i,j) element in row-major or column-major order and issues register-file reads with fixed 1-cycle read latency.
- Buffers returned elements and streams them out under a valid/ready handshake with full backpressure support.
- Sits between the register file and the memory interface; it is the successor store path with sizing, ordering modes, buffering and error reporting.

Parameters:
- FP, 32, element width in bits (32 or 64).
- MBITS, 3, row-index width minus 1; row fields are MBITS+1 bits.
- NBITS, 3, column-index width minus 1; column fields are NBITS+1 bits.
- M_MAX, 8, largest legal row count.
- N_MAX, 8, largest legal column count.
- BUF_DEPTH, 4, output buffer entries; must be ≥2.

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous reset, active low.
- store_en_in  input  1  start request, sampled only in IDLE.
- col_major_in  input  1  traversal order, latched at start: 0 = row-major, 1 = column-major.
- m_size_in  input  MBITS+1  row count, latched at start.
- n_size_in  input  NBITS+1  column count, latched at start.
- busy_out  output  1  high from accepted start until the last element is accepted.
- done_out  output  1  one-cycle pulse when the last element is accepted.
- error_out  output  1  one-cycle pulse when a start is rejected.
- reg_rd_en_out  output  1  register-file read strobe.
- reg_i_store_loc_out  output  MBITS+1  read row.
- reg_j_store_loc_out  output  NBITS+1  read column.
- reg_element_in  input  FP  read data, valid exactly 1 cycle after reg_rd_en_out.
- mem_store_en_out  output  1  output valid.
- mem_ready_in  input  1  sink ready.
- mem_store_element_out  output  FP  element.
- mem_i_out  output  MBITS+1  element row.
- mem_j_out  output  NBITS+1  element column.
- mem_last_out  output  1  marks the final element.
- mem_m_store_size_out  output  MBITS+1  latched M, stable while busy.
- mem_n_store_size_out  output  NBITS+1  latched N, stable while busy.

Behaviour:
- Reset (rst=0 at a clock edge): state IDLE; pointers, buffer and in-flight flag cleared; all outputs 0. Reset mid-transfer aborts immediately with no done_out; buffered data is discarded.
- IDLE: on store_en_in=1:
  - If m_size_in is 0 or >M_MAX, or n_size_in is 0 or >N_MAX: pulse error_out next cycle and stay in IDLE.
  - Otherwise latch sizes and mode, set i=j=0, and go to STREAM.
- STREAM:
  - Issue a read (reg_rd_en_out=1 with the current i,j) only when buffer occupancy + in-flight + (1 if an element is popped this cycle) allows it; the aim is that the buffer never overflows.
  - After each issued read, advance the pointer:
    - Row-major: j increments; at j=N-1, j wraps to 0 and i increments.
    - Column-major: i increments; at i=M-1, i wraps to 0 and j increments.
  - After issuing element (M-1,N-1) in row-major or the final column's last row in column-major, go to DRAIN.
- DRAIN: no reads issued; wait until the buffer is empty and no read is in flight.
- Completion: on the cycle the last element is popped, pulse done_out and go to IDLE. done_out and busy_out fall together.
- Buffer write and read:
  - Return data is written at the edge ending the return cycle, tagged with its (i,j).
  - The head of the buffer drives the mem_* outputs directly.
  - A pop occurs when mem_store_en_out & mem_ready_in.
  - A simultaneous push and pop is legal at full occupancy.
- Handshake: once mem_store_en_out is asserted, the element, i, j and last outputs hold stable until the pop.
- Latency and throughput:
  - Start accepted at edge E0 → first read in cycle 1 → first mem_store_en_out in cycle 3.
  - With mem_ready_in held high, one element per cycle; a 1x1 matrix gives done_out in cycle 3.
- store_en_in while busy is ignored, with no error.
- Size outputs are 0 in IDLE.

Test Plan:
- Row-major 2x3 store, elements 0x3F800000+k, ready high → six beats in order (0,0)(0,1)(0,2)(1,0)(1,1)(1,2), mem_last_out on beat 6, done_out in cycle 8, mem sizes read 2/3 throughout.
- Column-major 3x2 store → order (0,0)(1,0)(2,0)(0,1)(1,1)(2,1); no read issued twice.
- 4x4 store with mem_ready_in toggling 1,0,0,1 repeating → all 16 elements delivered exactly once with no loss or duplication; outputs stable while stalled; reg_rd_en_out stalls once BUF_DEPTH is reached.
- Start with m_size_in=0, then with n_size_in=N_MAX+1 → error_out pulses once each, busy_out stays 0, no reads issued.
- Assert rst=0 after 5 elements of an 8x8 store → the next cycle has all outputs 0 and no done_out; a fresh 1x1 store then completes in 3 cycles.
- Pulse store_en_in again during a busy 2x2 store → ignored; exactly 4 beats and one done_out.

Source files
------------

// File: rtl/mpu_store_stream.sv
//------------------------------------------------------------------------------
// Module   : mpu_store_stream
// Purpose  : Streams one matrix from the MPU register file to a memory sink,
//            row- or column-major, with a small buffered valid/ready output.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mpu_store_stream #(
    parameter int FP        = 32,
    parameter int MBITS     = 3,
    parameter int NBITS     = 3,
    parameter int M_MAX     = 8,
    parameter int N_MAX     = 8,
    parameter int BUF_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             store_en_in,
    input  logic             col_major_in,
    input  logic [MBITS:0]   m_size_in,
    input  logic [NBITS:0]   n_size_in,
    output logic             busy_out,
    output logic             done_out,
    output logic             error_out,
    output logic             reg_rd_en_out,
    output logic [MBITS:0]   reg_i_store_loc_out,
    output logic [NBITS:0]   reg_j_store_loc_out,
    input  logic [FP-1:0]    reg_element_in,
    output logic             mem_store_en_out,
    input  logic             mem_ready_in,
    output logic [FP-1:0]    mem_store_element_out,
    output logic [MBITS:0]   mem_i_out,
    output logic [NBITS:0]   mem_j_out,
    output logic             mem_last_out,
    output logic [MBITS:0]   mem_m_store_size_out,
    output logic [NBITS:0]   mem_n_store_size_out
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_C  = (CNT_W + 1)'(BUF_DEPTH);
    localparam logic [MBITS:0]   M_MAX_C  = (MBITS + 1)'(M_MAX);
    localparam logic [NBITS:0]   N_MAX_C  = (NBITS + 1)'(N_MAX);
    localparam logic [MBITS:0]   M_ONE    = (MBITS + 1)'(1);
    localparam logic [NBITS:0]   N_ONE    = (NBITS + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t           state;
    logic             col_major;
    logic [MBITS:0]   m_size;
    logic [NBITS:0]   n_size;
    logic [MBITS:0]   i_ptr;
    logic [NBITS:0]   j_ptr;
    logic             error_q;

    logic             inflight;
    logic             inflight_last;
    logic [MBITS:0]   inflight_i;
    logic [NBITS:0]   inflight_j;

    logic [FP-1:0]    buf_data [BUF_DEPTH];
    logic [MBITS:0]   buf_i    [BUF_DEPTH];
    logic [NBITS:0]   buf_j    [BUF_DEPTH];
    logic             buf_last [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;

    logic             head_valid;
    logic             pop;
    logic             push;
    logic             rd_en;
    logic             i_last;
    logic             j_last;
    logic             size_ok;
    logic             done;
    logic [CNT_W:0]   occupancy;
    logic [CNT_W:0]   limit;

    assign head_valid = (count != '0);
    assign pop        = head_valid & mem_ready_in;
    assign push       = inflight;

    // A slot freed by this cycle's pop may be claimed by a read issued now.
    assign occupancy  = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
    assign limit      = DEPTH_C + {{CNT_W{1'b0}}, pop};
    assign rd_en      = (state == S_STREAM) && (occupancy < limit);

    assign i_last     = (i_ptr == m_size - M_ONE);
    assign j_last     = (j_ptr == n_size - N_ONE);
    assign size_ok    = (m_size_in != '0) && (m_size_in <= M_MAX_C) &&
                        (n_size_in != '0) && (n_size_in <= N_MAX_C);
    assign done       = (state == S_DRAIN) && pop && buf_last[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= S_IDLE;
            col_major     <= 1'b0;
            m_size        <= '0;
            n_size        <= '0;
            i_ptr         <= '0;
            j_ptr         <= '0;
            error_q       <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            inflight_i    <= '0;
            inflight_j    <= '0;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
        end else begin
            error_q  <= 1'b0;
            inflight <= rd_en;
            if (rd_en) begin
                inflight_i    <= i_ptr;
                inflight_j    <= j_ptr;
                inflight_last <= i_last & j_last;
            end

            if (push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase

            case (state)
                S_IDLE: begin
                    if (store_en_in) begin
                        if (size_ok) begin
                            col_major <= col_major_in;
                            m_size    <= m_size_in;
                            n_size    <= n_size_in;
                            i_ptr     <= '0;
                            j_ptr     <= '0;
                            state     <= S_STREAM;
                        end else begin
                            error_q   <= 1'b1;
                        end
                    end
                end
                S_STREAM: begin
                    if (rd_en) begin
                        if (i_last && j_last) begin
                            state <= S_DRAIN;
                        end else if (!col_major) begin
                            if (j_last) begin
                                j_ptr <= '0;
                                i_ptr <= i_ptr + M_ONE;
                            end else begin
                                j_ptr <= j_ptr + N_ONE;
                            end
                        end else begin
                            if (i_last) begin
                                i_ptr <= '0;
                                j_ptr <= j_ptr + N_ONE;
                            end else begin
                                i_ptr <= i_ptr + M_ONE;
                            end
                        end
                    end
                end
                S_DRAIN: begin
                    if (done) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Buffer storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_data[wr_ptr] <= reg_element_in;
            buf_i[wr_ptr]    <= inflight_i;
            buf_j[wr_ptr]    <= inflight_j;
            buf_last[wr_ptr] <= inflight_last;
        end
    end

    assign busy_out              = (state != S_IDLE);
    assign done_out              = done;
    assign error_out             = error_q;
    assign reg_rd_en_out         = rd_en;
    assign reg_i_store_loc_out   = rd_en ? i_ptr : '0;
    assign reg_j_store_loc_out   = rd_en ? j_ptr : '0;
    assign mem_store_en_out      = head_valid;
    assign mem_store_element_out = head_valid ? buf_data[rd_ptr] : '0;
    assign mem_i_out             = head_valid ? buf_i[rd_ptr]    : '0;
    assign mem_j_out             = head_valid ? buf_j[rd_ptr]    : '0;
    assign mem_last_out          = head_valid & buf_last[rd_ptr];
    assign mem_m_store_size_out  = busy_out ? m_size : '0;
    assign mem_n_store_size_out  = busy_out ? n_size : '0;

endmodule

`default_nettype wire
